bicubic_stream: RTL and testbench
=================================

BICUBIC_STREAM -- requirements
Module: bicubic_stream

Interface
REQ-001 Parameter PIX_W, default 8: pixel width, unsigned.
REQ-002 Parameter FRAC_W, default 8: fraction width of position x, unsigned Q0.FRAC_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  taps, position and mode are presented.
REQ-006 in_ready  output  1  block can accept a transaction.
REQ-007 in_pix  input  4*PIX_W  taps P(-1),P(0),P(1),P(2); P(-1) in the LSBs.
REQ-008 in_frac  input  FRAC_W  position x between P(0) and P(1).
REQ-009 in_mode  input  1  0 = Catmull-Rom bicubic, 1 = linear.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_pix  output  PIX_W  interpolated, clamped pixel.

Function
REQ-013 Input handshake fires when in_valid and in_ready are both high; in_pix, in_frac and in_mode are captured on that edge.
REQ-014 in_ready shall be high only in IDLE, so at most one transaction is in flight.
REQ-015 FSM states: IDLE, POW2, POW3, W01, W23, MAC, OUT; IDLE->POW2 on input fire, then one state per cycle to OUT, OUT->IDLE on output fire, else hold.
REQ-016 out_valid shall be high exactly in OUT; it asserts on the 6th rising edge after the input-fire edge, in both modes.
REQ-017 While out_valid is high and out_ready is low, out_pix shall hold stable.
REQ-018 Output handshake fires when out_valid and out_ready are both high; the FSM returns to IDLE on that edge, and in_ready rises in the following cycle.
REQ-019 POW2: x2 = (x*x + 2^(FRAC_W-1)) >> FRAC_W; POW3: x3 = (x2*x + 2^(FRAC_W-1)) >> FRAC_W; one shared multiplier.
REQ-020 The constant 1 is represented as 2^FRAC_W, on FRAC_W+1 bits.
REQ-021 Bicubic weights, in half-units (coefficient vectors over [1, x, x2, x3]):
- h0 = [0, -1, 2, -1]
- h1 = [2, 0, -5, 3]
- h2 = [0, 1, 4, -3]
- h3 = [0, 0, -1, 1]
REQ-022 W01 computes h0 and h1; W23 computes h2 and h3. Each weight is signed, FRAC_W+5 bits, exact, with no intermediate rounding.
REQ-023 Linear mode weights, in half-units: h0 = 0, h1 = 2*(2^FRAC_W - x), h2 = 2*x, h3 = 0.
REQ-024 MAC: S = sum of hk*Pk, signed, PIX_W+FRAC_W+8 bits, with no overflow for any input.
REQ-025 Rounding: R = (S + 2^FRAC_W) >>> (FRAC_W+1), using an arithmetic shift.
REQ-026 Clamping: out_pix = 0 if R < 0; 2^PIX_W-1 if R > 2^PIX_W-1; otherwise R. The result is registered on entry to OUT.
REQ-027 x = 0 yields out_pix = P(0) exactly in both modes.
REQ-028 in_valid arriving in any non-IDLE state shall be ignored, with no corruption of the transaction in flight.

Reset
REQ-029 On rst: state = IDLE; in_ready = 1 in the next cycle; out_valid = 0; out_pix = 0; all datapath registers = 0.
REQ-030 rst asserted mid-transaction shall abort it; no out_valid shall be produced for the aborted transaction.
REQ-031 rst has priority over any simultaneous handshake.

Structure
REQ-032 Package bicubic_pkg shall hold:
- the PIX_W and FRAC_W defaults
- the FSM state encoding
- the half-unit coefficient table h0..h3
- the mode encoding
REQ-033 Sub-module bicubic_weight_gen shall be instantiated once: inputs x, x2, x3, mode and pair select; output two weights.
REQ-034 At most two general multipliers are shared across states in addition to the weight constant-multiplies.

Verification (PIX_W = 8, FRAC_W = 8)
REQ-035 Bicubic, P = 00,10,20,30 (hex), x = 128 -> out_pix = 0x18, out_valid on the 6th edge after fire.
REQ-036 Bicubic overshoot, P = 0,255,255,0, x = 128 -> 255; undershoot, P = 255,0,0,255, x = 128 -> 0.
REQ-037 Linear, P(0) = 0x10, P(1) = 0x20, x = 64 -> 0x14; x = 0 in either mode -> P(0).
REQ-038 Backpressure: out_ready held low for 10 cycles -> out_pix stable, in_ready low; release -> IDLE, and back-to-back transactions complete every 7 cycles.
REQ-039 rst pulsed in state W01 -> no out_valid; the next transaction returns a correct result.

Source files
------------

// File: rtl/bicubic_pkg.sv
// Shared constants for the bicubic stream interpolator: widths, states, coefficients.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bicubic_pkg;

    localparam int PIX_W_DEF  = 8;
    localparam int FRAC_W_DEF = 8;

    // One state per pipeline step; a single transaction walks them in order.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POW2 = 3'd1,
        POW3 = 3'd2,
        W01  = 3'd3,
        W23  = 3'd4,
        MAC  = 3'd5,
        OUT  = 3'd6
    } state_e;

    typedef enum logic {
        MODE_CUBIC  = 1'b0,
        MODE_LINEAR = 1'b1
    } mode_e;

    // Catmull-Rom weights in half-units, rows h0..h3, columns over [1, x, x^2, x^3].
    localparam int signed H_COEF [4][4] = '{
        '{ 0, -1,  2, -1},
        '{ 2,  0, -5,  3},
        '{ 0,  1,  4, -3},
        '{ 0,  0, -1,  1}
    };

endpackage

// File: rtl/bicubic_weight_gen.sv
// Produces one pair of tap weights (h0,h1 or h2,h3) in half-units from x, x^2, x^3.
// Latency: combinational.
// Backpressure: none; the caller registers the outputs.
module bicubic_weight_gen
    import bicubic_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic [FRAC_W-1:0]        x_i,
    input  logic [FRAC_W:0]          x2_i,
    input  logic [FRAC_W:0]          x3_i,
    input  logic                     mode_i,
    input  logic                     sel_i,
    output logic signed [FRAC_W+4:0] wa_o,
    output logic signed [FRAC_W+4:0] wb_o
);
    localparam int WW = FRAC_W + 5;
    typedef logic signed [WW-1:0] w_t;

    localparam w_t ONE = w_t'(2**FRAC_W);

    // Exact polynomial weight; small constant multiplies only.
    function automatic w_t poly(input int k, input w_t a, input w_t b, input w_t c);
        return w_t'(H_COEF[k][0]) * ONE + w_t'(H_COEF[k][1]) * a
             + w_t'(H_COEF[k][2]) * b   + w_t'(H_COEF[k][3]) * c;
    endfunction

    w_t xs, x2s, x3s;
    w_t h0, h1, h2, h3;

    assign xs  = w_t'(x_i);
    assign x2s = w_t'(x2_i);
    assign x3s = w_t'(x3_i);

    // Select weight set by mode, then the requested pair.
    always_comb begin
        h0   = '0;
        h1   = '0;
        h2   = '0;
        h3   = '0;
        if (mode_i == MODE_LINEAR) begin
            h1 = (ONE - xs) + (ONE - xs);
            h2 = xs + xs;
        end else begin
            h0 = poly(0, xs, x2s, x3s);
            h1 = poly(1, xs, x2s, x3s);
            h2 = poly(2, xs, x2s, x3s);
            h3 = poly(3, xs, x2s, x3s);
        end
        wa_o = sel_i ? h2 : h0;
        wb_o = sel_i ? h3 : h1;
    end

endmodule

// File: rtl/bicubic_stream.sv
// 4-tap Catmull-Rom / linear interpolator, one transaction in flight at a time.
// Latency: out_valid 5 edges after the input-fire edge; 7-cycle back-to-back period.
// Backpressure: result held in OUT until out_ready; in_ready only in IDLE.
module bicubic_stream
    import bicubic_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*PIX_W-1:0]   in_pix,
    input  logic [FRAC_W-1:0]    in_frac,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PIX_W-1:0]     out_pix
);
    localparam int WW = FRAC_W + 5;
    localparam int PB = ((PIX_W > FRAC_W + 1) ? PIX_W : FRAC_W + 1) + 1;
    localparam int PW = WW + PB;
    localparam int SW = PIX_W + FRAC_W + 8;

    typedef logic signed [WW-1:0] w_t;
    typedef logic signed [PB-1:0] b_t;
    typedef logic signed [PW-1:0] p_t;
    typedef logic signed [SW-1:0] s_t;
    typedef logic [FRAC_W:0]      x_t;

    localparam p_t HALF  = p_t'(2**(FRAC_W-1));
    localparam s_t ONE_S = s_t'(2**FRAC_W);

    state_e             state_q, state_d;
    logic [4*PIX_W-1:0] pix_q;
    logic [FRAC_W-1:0]  frac_q;
    logic               mode_q;
    x_t                 x2_q, x3_q;
    w_t                 w0_q, w1_q, w2_q, w3_q;
    s_t                 acc_q;
    logic [PIX_W-1:0]   out_pix_q;

    w_t   op_a, op_c, wa, wb;
    b_t   op_b, op_d;
    p_t   prod_a, prod_b, pow_sum;
    x_t   pow_x;
    s_t   s_full, r;
    logic [PIX_W-1:0] clamp;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == OUT);
        case (state_q)
            IDLE:    if (in_valid) state_d = POW2;
            POW2:    state_d = POW3;
            POW3:    state_d = W01;
            W01:     state_d = W23;
            W23:     state_d = MAC;
            MAC:     state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Two shared multipliers: powers of x first, then tap products in W23/MAC.
    always_comb begin
        op_a = '0;
        op_b = '0;
        op_c = '0;
        op_d = '0;
        case (state_q)
            POW2: begin op_a = w_t'(frac_q); op_b = b_t'(frac_q); end
            POW3: begin op_a = w_t'(x2_q);   op_b = b_t'(frac_q); end
            W23: begin
                op_a = w0_q; op_b = b_t'(pix_q[0*PIX_W +: PIX_W]);
                op_c = w1_q; op_d = b_t'(pix_q[1*PIX_W +: PIX_W]);
            end
            MAC: begin
                op_a = w2_q; op_b = b_t'(pix_q[2*PIX_W +: PIX_W]);
                op_c = w3_q; op_d = b_t'(pix_q[3*PIX_W +: PIX_W]);
            end
            default: ;
        endcase
    end

    assign prod_a  = p_t'(op_a) * p_t'(op_b);
    assign prod_b  = p_t'(op_c) * p_t'(op_d);
    assign pow_sum = prod_a + HALF;
    assign pow_x   = x_t'(pow_sum >> FRAC_W);

    // Final sum, round-half-up by arithmetic shift, clamp to pixel range.
    always_comb begin
        s_full = acc_q + s_t'(prod_a) + s_t'(prod_b);
        r      = (s_full + ONE_S) >>> (FRAC_W + 1);
        if (r[SW-1])              clamp = '0;
        else if (|r[SW-2:PIX_W])  clamp = '1;
        else                      clamp = r[PIX_W-1:0];
    end

    bicubic_weight_gen #(.FRAC_W(FRAC_W)) u_wgen (
        .x_i    (frac_q),
        .x2_i   (x2_q),
        .x3_i   (x3_q),
        .mode_i (mode_q),
        .sel_i  (state_q == W23),
        .wa_o   (wa),
        .wb_o   (wb)
    );

    // Datapath registers, each loaded in its own step of the sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q     <= '0;
            frac_q    <= '0;
            mode_q    <= 1'b0;
            x2_q      <= '0;
            x3_q      <= '0;
            w0_q      <= '0;
            w1_q      <= '0;
            w2_q      <= '0;
            w3_q      <= '0;
            acc_q     <= '0;
            out_pix_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    pix_q  <= in_pix;
                    frac_q <= in_frac;
                    mode_q <= in_mode;
                end
                POW2: x2_q <= pow_x;
                POW3: x3_q <= pow_x;
                W01: begin
                    w0_q <= wa;
                    w1_q <= wb;
                end
                W23: begin
                    w2_q  <= wa;
                    w3_q  <= wb;
                    acc_q <= s_t'(prod_a) + s_t'(prod_b);
                end
                MAC:     out_pix_q <= clamp;
                default: ;
            endcase
        end
    end

    assign out_pix = out_pix_q;

endmodule

// File: tb/tb_bicubic_stream.sv
module tb_bicubic_stream;
    localparam int PIX_W  = 8;
    localparam int FRAC_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [4*PIX_W-1:0] in_pix = '0;
    logic [FRAC_W-1:0]  in_frac = '0;
    logic               in_mode = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [PIX_W-1:0]   out_pix;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_fire = 0;

    bicubic_stream #(.PIX_W(PIX_W), .FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .in_frac   (in_frac),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Reference: weights straight from the polynomial definitions, integer maths.
    function automatic int model(input logic [31:0] pix, input int x, input bit lin);
        int one, x2, x3, s, r;
        int h[4];
        int p[4];
        one = 1 << FRAC_W;
        for (int k = 0; k < 4; k++) p[k] = int'(pix[8*k +: 8]);
        x2 = (x * x + one / 2) >>> FRAC_W;
        x3 = (x2 * x + one / 2) >>> FRAC_W;
        if (lin) begin
            h[0] = 0; h[1] = 2 * (one - x); h[2] = 2 * x; h[3] = 0;
        end else begin
            h[0] = -x + 2 * x2 - x3;
            h[1] = 2 * one - 5 * x2 + 3 * x3;
            h[2] = x + 4 * x2 - 3 * x3;
            h[3] = x3 - x2;
        end
        s = 0;
        for (int k = 0; k < 4; k++) s += h[k] * p[k];
        r = (s + one) >>> (FRAC_W + 1);
        if (r < 0) return 0;
        if (r > (1 << PIX_W) - 1) return (1 << PIX_W) - 1;
        return r;
    endfunction

    // One transaction; junk is driven on the input while the block is busy.
    task automatic run_txn(input string tag, input logic [31:0] pix, input int x,
                           input bit lin, input int exp, input int hold, input bit b2b);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick; n++; end
        in_valid  = 1'b1;
        in_pix    = pix;
        in_frac   = FRAC_W'(x);
        in_mode   = lin;
        out_ready = (hold == 0);
        tick;
        if (b2b) chk({tag, "_period"}, cyc - last_fire, 7);
        last_fire = cyc;
        in_pix  = $urandom;
        in_frac = FRAC_W'($urandom);
        in_mode = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin tick; n++; end
        in_valid = 1'b0;
        // Five edges past the fire edge: the sixth edge counting the fire edge.
        chk({tag, "_latency"}, n, 5);
        chk({tag, "_busy_ready"}, in_ready, 0);
        chk({tag, "_pix"}, out_pix, exp);
        for (int i = 0; i < hold; i++) begin
            tick;
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_pix"}, out_pix, exp);
            chk({tag, "_hold_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        chk({tag, "_idle_ready"}, in_ready, 1);
        chk({tag, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        logic [31:0] rp;
        int          rx, rh, prev_hold, seen;
        bit          rl;

        rst = 1'b1;
        tick;
        tick;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pix", out_pix, 0);
        rst = 1'b0;

        run_txn("cr_ramp",  pk(8'h00, 8'h10, 8'h20, 8'h30), 128, 1'b0, 8'h18, 0, 1'b0);
        run_txn("cr_over",  pk(0, 255, 255, 0),             128, 1'b0, 255,   0, 1'b1);
        run_txn("cr_under", pk(255, 0, 0, 255),             128, 1'b0, 0,     0, 1'b1);
        run_txn("lin_64",   pk(8'h00, 8'h10, 8'h20, 8'h00), 64,  1'b1, 8'h14, 0, 1'b1);
        run_txn("lin_x0",   pk(8'h33, 8'h5a, 8'hc0, 8'h11), 0,   1'b1, 8'h5a, 0, 1'b1);
        run_txn("cr_x0",    pk(8'hff, 8'h5a, 8'h00, 8'hff), 0,   1'b0, 8'h5a, 0, 1'b1);
        run_txn("bp",       pk(8'h00, 8'h10, 8'h20, 8'h30), 128, 1'b0, 8'h18, 10, 1'b1);

        // Abort a transaction while it sits in W01.
        in_valid = 1'b1;
        in_pix   = pk(1, 200, 50, 9);
        in_frac  = 8'd200;
        in_mode  = 1'b0;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (out_valid) seen = 1;
        end
        chk("abort_no_valid", seen, 0);

        rp = pk(12, 240, 30, 77);
        run_txn("post_abort", rp, 99, 1'b0, model(rp, 99, 1'b0), 0, 1'b0);

        prev_hold = 0;
        for (int i = 0; i < 40; i++) begin
            rp = $urandom;
            rx = $urandom_range(0, (1 << FRAC_W) - 1);
            rl = 1'($urandom_range(0, 1));
            rh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_txn("rnd", rp, rx, rl, model(rp, rx, rl), rh, prev_hold == 0);
            prev_hold = rh;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
